// File: rtl/bus_adc_spi_if.sv
// SPI bus between the bus-voltage ADC master and the AD7476-class ADC.
interface bus_adc_spi_if;
  logic adc_cs_n;
  logic adc_sclk;
  logic adc_miso;

  modport master (
    output adc_cs_n,
    output adc_sclk,
    input  adc_miso
  );

  modport slave (
    input  adc_cs_n,
    input  adc_sclk,
    output adc_miso
  );
endinterface

// File: rtl/bus_adc_spi.sv
// Periodic SPI master for the 12-bit bus-voltage ADC.
// BUS_ADC_AVG_EN: report the mean of every 4 good samples.
module bus_adc_spi #(
  parameter int ADC_BITS      = 12,
  parameter int FRAME_BITS    = 16,
  parameter int LEAD_ZEROS    = 4,
  parameter int CLK_DIV       = 2,
  parameter int CS_SETUP      = 2,
  parameter int QUIET_CYCLES  = 8,
  parameter int SAMPLE_PERIOD = 500
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  bus_adc_spi_if.master       spi,
  output logic [ADC_BITS-1:0] sample_data,
  output logic                sample_valid,
  output logic                frame_error,
  output logic [15:0]         overrun_count
);

  localparam int PW   = $clog2(SAMPLE_PERIOD + 1);
  localparam int CMAX = (CS_SETUP > QUIET_CYCLES) ?
                        CS_SETUP : QUIET_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int HW   = $clog2(CLK_DIV + 1);
  localparam int BW   = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    QUIET
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         pc_q, pc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [HW-1:0]         ph_q, ph_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic                  cs_q, cs_d;
  logic                  sclk_q, sclk_d;
  logic [ADC_BITS-1:0]   data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [15:0]           ovr_q, ovr_d;

  logic                  tick;
  logic                  start;
  logic                  fend;
  logic                  good;
  logic [ADC_BITS-1:0]   word;

`ifdef BUS_ADC_AVG_EN
  logic [ADC_BITS+1:0]   acc_q, acc_d;
  logic [1:0]            acnt_q, acnt_d;
  logic [ADC_BITS+1:0]   sum;
  assign sum = acc_q + (ADC_BITS+2)'(word);
`endif

  assign tick = pc_q == PW'(SAMPLE_PERIOD - 1);
  assign good = sr_q[FRAME_BITS-1 -: LEAD_ZEROS] == '0;
  assign word = sr_q[FRAME_BITS-1-LEAD_ZEROS -: ADC_BITS];

  always_comb begin
    state_d = state_q;
    pc_d    = tick ? '0 : pc_q + PW'(1);
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    start   = 1'b0;
    fend    = 1'b0;
    unique case (state_q)
      IDLE: begin
        start = tick && enable;
      end
      SETUP: begin
        if (cnt_q == CW'(CS_SETUP - 1)) begin
          state_d = SHIFT;
          sclk_d  = 1'b0;
          ph_d    = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT: begin
        // frame ends one cycle after the last rising edge
        if (sclk_q && bit_q == BW'(FRAME_BITS)) begin
          fend    = 1'b1;
          cs_d    = 1'b1;
          state_d = QUIET;
          cnt_d   = '0;
        end else if (ph_q == HW'(CLK_DIV - 1)) begin
          ph_d   = '0;
          sclk_d = !sclk_q;
          if (!sclk_q) begin
            sr_d  = {sr_q[FRAME_BITS-2:0], spi.adc_miso};
            bit_d = bit_q + BW'(1);
          end
        end else begin
          ph_d = ph_q + HW'(1);
        end
      end
      QUIET: begin
        if (cnt_q == CW'(QUIET_CYCLES - 1)) begin
          state_d = IDLE;
          start   = tick && enable;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = SETUP;
      cs_d    = 1'b0;
      cnt_d   = '0;
    end
  end

  always_comb begin
    ovr_d = ovr_q;
    if (tick && enable && !start &&
        state_q != IDLE && ovr_q != 16'hFFFF) begin
      ovr_d = ovr_q + 16'd1;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = fend && !good;
`ifdef BUS_ADC_AVG_EN
    acc_d  = acc_q;
    acnt_d = acnt_q;
    if (!enable) begin
      acc_d  = '0;
      acnt_d = '0;
    end else if (fend && good) begin
      if (acnt_q == 2'd3) begin
        data_d  = ADC_BITS'(sum >> 2);
        valid_d = 1'b1;
        acc_d   = '0;
        acnt_d  = '0;
      end else begin
        acc_d  = sum;
        acnt_d = acnt_q + 2'd1;
      end
    end
`else
    if (fend && good) begin
      data_d  = word;
      valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      ph_q    <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= '0;
`ifdef BUS_ADC_AVG_EN
      acc_q   <= '0;
      acnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
`ifdef BUS_ADC_AVG_EN
      acc_q   <= acc_d;
      acnt_q  <= acnt_d;
`endif
    end
  end

  assign spi.adc_cs_n  = cs_q;
  assign spi.adc_sclk  = sclk_q;
  assign sample_data   = data_q;
  assign sample_valid  = valid_q;
  assign frame_error   = err_q;
  assign overrun_count = ovr_q;

endmodule

// File: tb/tb_bus_adc_spi.sv
// Bench for bus_adc_spi: timeline model plus directed frames.
module tb_bus_adc_spi;

  localparam int P    = 500;
  localparam int CSU  = 2;
  localparam int CD   = 2;
  localparam int FB   = 16;
  localparam int QC   = 8;
  localparam int FEND = CSU + (2*FB - 1)*CD + 1;
  localparam int BUSY = FEND + QC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic        frame_error;
  logic [15:0] overrun_count;

  logic        rst60_n = 1'b0;
  logic        en60 = 1'b0;
  logic [11:0] d60;
  logic        v60;
  logic        e60;
  logic [15:0] o60;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] next_word = 16'h0;
  logic [15:0] cur_word = 16'h0;
  int          adc_idx = 0;
  int          adc60_idx = 0;
  localparam logic [15:0] W60 = 16'h0555;

  bus_adc_spi_if spi();
  bus_adc_spi_if spi60();

  bus_adc_spi u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .spi           (spi),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .frame_error   (frame_error),
    .overrun_count (overrun_count)
  );

  bus_adc_spi #(.SAMPLE_PERIOD(60)) u_dut60 (
    .clk           (clk),
    .rst_n         (rst60_n),
    .enable        (en60),
    .spi           (spi60),
    .sample_data   (d60),
    .sample_valid  (v60),
    .frame_error   (e60),
    .overrun_count (o60)
  );

  always #10 clk = ~clk;

  // ADC models: next bit appears on each SCLK fall
  always @(negedge spi.adc_cs_n) adc_idx = 0;
  always @(negedge spi.adc_sclk)
    if (!spi.adc_cs_n && adc_idx < 16) begin
      spi.adc_miso = cur_word[15 - adc_idx];
      adc_idx++;
    end

  always @(negedge spi60.adc_cs_n) adc60_idx = 0;
  always @(negedge spi60.adc_sclk)
    if (!spi60.adc_cs_n && adc60_idx < 16) begin
      spi60.adc_miso = W60[15 - adc60_idx];
      adc60_idx++;
    end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cs_n"}, 32'(spi.adc_cs_n), 1);
    chk({tag, "_sclk"}, 32'(spi.adc_sclk), 1);
    chk({tag, "_data"}, 32'(sample_data), 0);
    chk({tag, "_valid"}, 32'(sample_valid), 0);
    chk({tag, "_err"}, 32'(frame_error), 0);
    chk({tag, "_ovr"}, 32'(overrun_count), 0);
  endtask

  // Timeline model of the main DUT
  initial begin : model
    int          pc, n, e0, off, acc, acnt;
    bit          started, r;
    logic [15:0] w, e_ovr;
    logic [11:0] e_data;
    logic        e_cs, e_sclk, e_v, e_e;
    pc = 0; n = 0; e0 = 0; acc = 0; acnt = 0;
    started = 0; w = 0; e_ovr = 0; e_data = 0;
    forever begin
      @(posedge clk);
      r = rst_n;
      #1;
      e_v = 0;
      e_e = 0;
      if (!r) begin
        pc = 0; n = 0; started = 0;
        e_ovr = 0; e_data = 0; acc = 0; acnt = 0;
      end else begin
        n++;
        if (pc == P - 1) begin
          pc = 0;
          if (enable) begin
            if (!started || n - e0 >= BUSY) begin
              started = 1;
              e0 = n;
              w = next_word;
              cur_word = next_word;
            end else if (e_ovr != 16'hFFFF) begin
              e_ovr++;
            end
          end
        end else begin
          pc++;
        end
        off = n - e0;
        if (started && off == FEND) begin
          if (w[15:12] != 0) e_e = 1;
`ifdef BUS_ADC_AVG_EN
          else if (enable) begin
            acc += int'(w[11:0]);
            acnt++;
            if (acnt == 4) begin
              e_data = 12'(acc / 4);
              e_v = 1;
              acc = 0;
              acnt = 0;
            end
          end
`else
          else begin
            e_data = w[11:0];
            e_v = 1;
          end
`endif
        end
`ifdef BUS_ADC_AVG_EN
        if (!enable) begin
          acc = 0;
          acnt = 0;
        end
`endif
      end
      off = n - e0;
      e_cs = !(started && off < FEND);
      e_sclk = !(started && off >= CSU && off < FEND - 1 &&
                 ((off - CSU) / CD) % 2 == 0);
      chk("m_cs_n", 32'(spi.adc_cs_n), 32'(e_cs));
      chk("m_sclk", 32'(spi.adc_sclk), 32'(e_sclk));
      chk("m_data", 32'(sample_data), 32'(e_data));
      chk("m_valid", 32'(sample_valid), 32'(e_v));
      chk("m_err", 32'(frame_error), 32'(e_e));
      chk("m_ovr", 32'(overrun_count), 32'(e_ovr));
    end
  end

  task automatic wait_fall(input int maxc, output int edges);
    edges = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk);
      #2;
      if (!spi.adc_cs_n) begin
        edges = i;
        break;
      end
    end
    chk("cs_fall_seen", 32'(edges != 0), 1);
  endtask

  task automatic measure(input int drop_at, input int rst_at,
                         output int lowc, output int rises,
                         output int nv, output int ne,
                         output int vrise, output logic [11:0] dat);
    logic pcs, psc;
    lowc = 1; rises = 0; nv = 0; ne = 0; vrise = 0;
    pcs = 1'b0;
    psc = spi.adc_sclk;
    for (int i = 0; i < BUSY + 4; i++) begin
      @(posedge clk);
      #2;
      if (!spi.adc_cs_n) lowc++;
      if (spi.adc_sclk && !psc) begin
        rises++;
        if (rises == drop_at) enable = 1'b0;
        if (rises == rst_at) begin
          rst_n = 1'b0;
          #1;
          chk_reset("t4_async");
          break;
        end
      end
      if (sample_valid) begin
        nv++;
        if (spi.adc_cs_n && !pcs) vrise++;
      end
      if (frame_error) ne++;
      pcs = spi.adc_cs_n;
      psc = spi.adc_sclk;
    end
    dat = sample_data;
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          e, lowc, rises, nv, ne, vr, lows, tv;
    logic [11:0] dat;
    logic [15:0] avg_w [4];
    int          falls[$];
    logic        p60;
    avg_w = '{16'h0BB8, 16'h0BBC, 16'h0BC0, 16'h0BC5};

    repeat (3) @(negedge clk);
    #1;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    next_word = 16'h0C5F;

    wait_fall(600, e);
    chk("t1_first_fall_edge", 32'(e), 500);
    measure(0, 0, lowc, rises, nv, ne, vr, dat);
    chk("t1_cs_low_cycles", 32'(lowc), 65);
    chk("t1_sclk_rises", 32'(rises), 16);
    chk("t1_valid_count", 32'(nv), 1);
    chk("t1_valid_at_cs_rise", 32'(vr), 1);
    chk("t1_err_count", 32'(ne), 0);
`ifndef BUS_ADC_AVG_EN
    chk("t1_data", 32'(dat), 3167);
`endif

    next_word = 16'h8C5F;
    wait_fall(600, e);
    measure(0, 0, lowc, rises, nv, ne, vr, dat);
    chk("t2_err_count", 32'(ne), 1);
    chk("t2_valid_count", 32'(nv), 0);
`ifndef BUS_ADC_AVG_EN
    chk("t2_data_held", 32'(dat), 3167);
`endif

    next_word = 16'h0ABC;
    wait_fall(600, e);
    measure(8, 0, lowc, rises, nv, ne, vr, dat);
    chk("t3_cs_low_cycles", 32'(lowc), 65);
`ifndef BUS_ADC_AVG_EN
    chk("t3_valid_count", 32'(nv), 1);
    chk("t3_data", 32'(dat), 2748);
`endif
    lows = 0;
    repeat (2000) begin
      @(posedge clk);
      #2;
      if (!spi.adc_cs_n) lows++;
    end
    chk("t3_no_start", 32'(lows), 0);
    chk("t3_ovr", 32'(overrun_count), 0);

    @(negedge clk);
    enable = 1'b1;
    next_word = 16'h0123;
    wait_fall(600, e);
    measure(0, 10, lowc, rises, nv, ne, vr, dat);
    chk("t4_rises_before_rst", 32'(rises), 10);
    chk("t4_no_valid", 32'(nv), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_fall(600, e);
    chk("t4_first_fall_edge", 32'(e), 500);
    measure(0, 0, lowc, rises, nv, ne, vr, dat);
`ifndef BUS_ADC_AVG_EN
    chk("t4_data", 32'(dat), 291);
`endif

    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    tv = 0;
    for (int k = 0; k < 4; k++) begin
      next_word = avg_w[k];
      wait_fall(600, e);
      measure(0, 0, lowc, rises, nv, ne, vr, dat);
      tv += nv;
    end
`ifdef BUS_ADC_AVG_EN
    chk("t6_valid_total", 32'(tv), 1);
    chk("t6_avg_data", 32'(dat), 3006);
`else
    chk("t6_valid_total", 32'(tv), 4);
    chk("t6_last_data", 32'(dat), 3013);
`endif

    @(negedge clk);
    rst60_n = 1'b1;
    en60 = 1'b1;
    p60 = 1'b1;
    tv = 0;
    for (int i = 1; i <= 470; i++) begin
      @(posedge clk);
      #2;
      if (!spi60.adc_cs_n && p60) falls.push_back(i);
      if (v60) tv++;
      p60 = spi60.adc_cs_n;
    end
    chk("t5_fall_count", 32'(falls.size()), 4);
    if (falls.size() == 4) begin
      chk("t5_first_fall", 32'(falls[0]), 60);
      for (int k = 1; k < 4; k++)
        chk("t5_spacing", 32'(falls[k] - falls[k-1]), 120);
    end
    chk("t5_ovr", 32'(o60), 3);
    chk("t5_err", 32'(e60), 0);
`ifndef BUS_ADC_AVG_EN
    chk("t5_valid_count", 32'(tv), 3);
    chk("t5_data", 32'(d60), 1365);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_adc_spi.md
Name: bus_adc_spi

Overview:
SPI master for the external 12-bit bus-voltage ADC (AD7476-class, 16-bit frame: 4 leading zeros + 12 data bits, MSB first). Runs periodic conversions and presents each result as a parallel word with a one-cycle valid strobe. The word and strobe feed the overvoltage protection block directly. Also flags malformed frames and conversion overruns for telemetry.

Parameters:
ADC_BITS, 12, data bits per sample
FRAME_BITS, 16, SCLK cycles per frame
LEAD_ZEROS, 4, leading bits that must read 0; LEAD_ZEROS+ADC_BITS <= FRAME_BITS
CLK_DIV, 2, clk cycles per SCLK half-period (>=1); 12.5 MHz SCLK at 50 MHz clk
CS_SETUP, 2, clk cycles from cs_n fall to first SCLK fall (>=1)
QUIET_CYCLES, 8, minimum clk cycles with cs_n high between frames (>=1)
SAMPLE_PERIOD, 500, clk cycles between conversion starts (100 kSPS)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  start new conversions while high
adc_cs_n  out  1  ADC chip select, active low
adc_sclk  out  1  SPI clock, idles high
adc_miso  in  1  ADC serial data
sample_data  out  ADC_BITS  last good conversion result
sample_valid  out  1  one-cycle pulse when sample_data updates
frame_error  out  1  one-cycle pulse when leading bits are nonzero
overrun_count  out  16  start ticks dropped because the FSM was busy; saturates at 0xFFFF

Behaviour:
- Reset values (asynchronous, take effect immediately, including mid-frame):
  - adc_cs_n=1, adc_sclk=1
  - sample_data=0, sample_valid=0, frame_error=0, overrun_count=0
  - period counter=0, FSM=IDLE
- Period counter: free-running 0..SAMPLE_PERIOD-1, independent of enable; "tick" = counter at SAMPLE_PERIOD-1.
- FSM states: IDLE, SETUP, SHIFT, QUIET.
- IDLE: on tick with enable=1 -> adc_cs_n drives 0 at that edge (E0); go to SETUP.
- SETUP: count CS_SETUP cycles; at E0+CS_SETUP drive adc_sclk=0; go to SHIFT.
- SHIFT, per bit k=1..FRAME_BITS:
  - adc_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - adc_miso is captured into a shift register (MSB first) on the clk edge that drives adc_sclk 0->1, at E0+CS_SETUP+(2k-1)*CLK_DIV.
  - After the last bit's rising edge, no further low phase.
- Frame end, edge E0+CS_SETUP+(2*FRAME_BITS-1)*CLK_DIV+1 (65 cycles after E0 with defaults):
  - adc_cs_n=1.
  - If the first LEAD_ZEROS captured bits are all 0: sample_data <= next ADC_BITS bits and sample_valid=1 for this cycle. Trailing bits are ignored.
  - Otherwise frame_error=1 for this cycle, sample_data holds its previous value, no valid.
  - Go to QUIET.
- QUIET: hold cs_n high for QUIET_CYCLES, then go to IDLE.
- A tick in SETUP, SHIFT or QUIET with enable=1 is dropped and overrun_count increments (saturating). A tick that lands exactly in the cycle QUIET exits to IDLE starts a conversion.
- enable only gates starts. Deasserting it mid-frame lets the frame complete normally (valid or error) and prevents the next start.
- sample_valid and frame_error are never both high, and each is high for exactly one cycle per frame.
- The SCLK phase counter and bit counter are sized from CLK_DIV and FRAME_BITS with no wrap within a frame.

Optional Feature:
Macro BUS_ADC_AVG_EN.
- Defined: good samples accumulate into an (ADC_BITS+2)-bit sum. On every 4th good sample, sample_data = sum>>2 (truncating) and sample_valid pulses; the sum then clears. Frames with errors are excluded from the count. Reset and enable=0 clear the accumulator and count.
- Undefined: every good frame produces sample_valid with the raw value, and no accumulator logic is synthesized.

Test Plan:
1. Defaults, enable=1, ADC model returns 0x0C5F -> cs_n low for exactly 65 cycles; 16 SCLK rising edges, each CLK_DIV=2 cycles high and low; sample_data=12'd3167 with a single-cycle sample_valid coincident with cs_n rise.
2. Model returns 0x8C5F -> frame_error pulses once, no sample_valid, sample_data keeps its prior value (3167).
3. enable dropped at the 8th SCLK rise -> frame completes with valid data; no further cs_n fall over the next 2000 cycles; overrun_count stays 0.
4. rst_n asserted at the 10th SCLK rise -> adc_cs_n=1, adc_sclk=1, all outputs 0 before the next clk edge; no valid. After release with enable=1, first cs_n fall when the period counter reaches 499.
5. SAMPLE_PERIOD=60 (less than 65+8) -> alternate ticks dropped; overrun_count increments once per dropped tick; cs_n fall-to-fall spacing is 120 cycles.
6. BUS_ADC_AVG_EN defined, samples 3000, 3004, 3008, 3013 -> exactly one sample_valid, after the 4th frame, with sample_data=3006.
